// File: rtl/hex_display_driver.sv
// Multi-digit registered hex display driver. It latches a hex value and drives
// active-low seven-segment fields, with global enable, leading-zero blanking and per-digit blink.
module hex_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int CNT_W      = 25
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    enable,
  input  logic                    lzb,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    blink_phase
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  // Active-low segment pattern, bit order g..a (bit 6 = g, bit 0 = a).
  function automatic logic [6:0] decode_hex(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    phase_r;
  logic [7*NUM_DIGITS-1:0] segs_r;
  logic [7*NUM_DIGITS-1:0] segs_next_s;
  logic [NUM_DIGITS-1:0]   lead_zero_s;
  logic                    wrap_s;

  assign segs        = segs_r;
  assign blink_phase = phase_r;

  // Detect the last count of a blink half-period.
  always_comb begin
    wrap_s = (cnt_r == CNT_LAST);
  end

  // Value capture register.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= '0;
    end else if (load) begin
      value_r <= value;
    end else begin
      value_r <= value_r;
    end
  end

  // Free-running blink divider. It is unaffected by load or enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (wrap_s) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
      phase_r <= phase_r;
    end
  end

  // Next segment image. A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic higher_zero;
    logic blank;
    segs_next_s = {(7*NUM_DIGITS){1'b1}};
    lead_zero_s = '0;
    higher_zero = 1'b1;
    blank       = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero    = higher_zero & (value_r[4*i +: 4] == 4'h0);
      lead_zero_s[i] = higher_zero;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      // Digit 0 is never blanked by lzb, so a zero value still shows a single "0".
      blank = !enable
              || (lzb && lead_zero_s[i] && (i != 0))
              || (blink_mask[i] && phase_r);
      if (blank) begin
        segs_next_s[7*i +: 7] = SEG_BLANK;
      end else begin
        segs_next_s[7*i +: 7] = decode_hex(value_r[4*i +: 4]);
      end
    end
  end

  // Registered segment outputs. All digits are dark while in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      segs_r <= {(7*NUM_DIGITS){1'b1}};
    end else begin
      segs_r <= segs_next_s;
    end
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver with NUM_DIGITS=4 and BLINK_DIV=4.
module tb_hex_display_driver;

  localparam int ND = 4;
  localparam int BD = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset, load, enable, lzb;
  logic [15:0]   value;
  logic [3:0]    blink_mask;
  logic [27:0]   segs;
  logic          blink_phase;
  int            total = 0;
  int            bad = 0;

  localparam logic [27:0] ALL_DARK = 28'hFFFFFFF;
  localparam logic [27:0] ZEROS    = {7'h40, 7'h40, 7'h40, 7'h40};

  hex_display_driver #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .load(load), .value(value), .enable(enable),
    .lzb(lzb), .blink_mask(blink_mask), .segs(segs), .blink_phase(blink_phase)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; value = 16'h1234; enable = 1'b1; lzb = 1'b0; blink_mask = 4'b0000;
    tick(); tick(); tick();
    total++;
    if (segs !== ALL_DARK) begin bad++; $display("FAIL reset_segs got=%h exp=%h", segs, ALL_DARK); end
    total++;
    if (blink_phase !== 1'b0) begin bad++; $display("FAIL reset_phase got=%b exp=0", blink_phase); end
    reset = 1'b0; load = 1'b0;
    tick();
    total++;
    if (segs !== ZEROS) begin bad++; $display("FAIL reset_discard_load got=%h exp=%h", segs, ZEROS); end
  endtask

  task automatic test_decode();
    logic [15:0] vals [4];
    logic [27:0] exps [4];
    vals[0] = 16'hFEDC; exps[0] = {7'h0E, 7'h06, 7'h21, 7'h46};
    vals[1] = 16'hBA98; exps[1] = {7'h03, 7'h08, 7'h10, 7'h00};
    vals[2] = 16'h7654; exps[2] = {7'h78, 7'h02, 7'h12, 7'h19};
    vals[3] = 16'h3210; exps[3] = {7'h30, 7'h24, 7'h79, 7'h40};
    enable = 1'b1; lzb = 1'b0; blink_mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      value = vals[k]; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      total++;
      if (segs !== exps[k]) begin bad++; $display("FAIL decode_%h got=%h exp=%h", vals[k], segs, exps[k]); end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [3];
    logic [27:0] exps [3];
    vals[0] = 16'h00A0; exps[0] = {7'h7F, 7'h7F, 7'h08, 7'h40};
    vals[1] = 16'h0000; exps[1] = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    vals[2] = 16'h0F00; exps[2] = {7'h7F, 7'h0E, 7'h40, 7'h40};
    lzb = 1'b1; enable = 1'b1; blink_mask = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      value = vals[k]; load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      total++;
      if (segs !== exps[k]) begin bad++; $display("FAIL lzb_%h got=%h exp=%h", vals[k], segs, exps[k]); end
    end
    lzb = 1'b0;
  endtask

  task automatic test_blink();
    logic [27:0] lit;
    logic [27:0] dim;
    logic        exp_ph;
    logic        prev_ph;
    lit = {7'h00, 7'h00, 7'h00, 7'h00};
    dim = {7'h00, 7'h7F, 7'h00, 7'h7F};
    enable = 1'b1; lzb = 1'b0; blink_mask = 4'b0101; value = 16'h8888;
    reset = 1'b1; load = 1'b0;
    tick();
    reset = 1'b0;
    // After the reset edge (n=0) the counter is n%4 and the phase is (n/4)%2.
    for (int n = 1; n <= 13; n++) begin
      load = (n == 1 || n == 6) ? 1'b1 : 1'b0;
      tick();
      exp_ph  = ((n / 4) % 2) == 1;
      prev_ph = (((n - 1) / 4) % 2) == 1;
      total++;
      if (blink_phase !== exp_ph) begin bad++; $display("FAIL blink_phase_n%0d got=%b exp=%b", n, blink_phase, exp_ph); end
      if (n >= 2) begin
        total++;
        if (segs !== (prev_ph ? dim : lit)) begin
          bad++; $display("FAIL blink_segs_n%0d got=%h exp=%h", n, segs, prev_ph ? dim : lit);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_enable();
    logic [27:0] exp_v;
    exp_v = {7'h79, 7'h24, 7'h30, 7'h19};
    blink_mask = 4'b0000; lzb = 1'b0; enable = 1'b0;
    value = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    total++;
    if (segs !== ALL_DARK) begin bad++; $display("FAIL enable_off got=%h exp=%h", segs, ALL_DARK); end
    enable = 1'b1;
    tick();
    total++;
    if (segs !== exp_v) begin bad++; $display("FAIL enable_on got=%h exp=%h", segs, exp_v); end
  endtask

  task automatic test_reset_mid_blink();
    logic exp_ph;
    enable = 1'b1; lzb = 1'b0; blink_mask = 4'b0101;
    reset = 1'b1; load = 1'b0;
    tick();
    reset = 1'b0;
    value = 16'h8888;
    for (int n = 1; n <= 6; n++) begin
      load = (n == 1) ? 1'b1 : 1'b0;
      tick();
    end
    total++;
    if (blink_phase !== 1'b1) begin bad++; $display("FAIL midblink_pre got=%b exp=1", blink_phase); end
    reset = 1'b1; load = 1'b1; value = 16'h1111;
    tick();
    total++;
    if (blink_phase !== 1'b0) begin bad++; $display("FAIL midblink_rst_phase got=%b exp=0", blink_phase); end
    total++;
    if (segs !== ALL_DARK) begin bad++; $display("FAIL midblink_rst_segs got=%h exp=%h", segs, ALL_DARK); end
    reset = 1'b0; load = 1'b0;
    for (int m = 1; m <= 4; m++) begin
      tick();
      exp_ph = (m == 4);
      total++;
      if (blink_phase !== exp_ph) begin bad++; $display("FAIL midblink_m%0d got=%b exp=%b", m, blink_phase, exp_ph); end
      if (m == 1) begin
        total++;
        if (segs !== ZEROS) begin bad++; $display("FAIL midblink_value_cleared got=%h exp=%h", segs, ZEROS); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_leading_zero();
    test_blink();
    test_enable();
    test_reset_mid_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Registered, parametrised multi-digit hex display driver for the board's HEX seven-segment displays.
- Latches a NUM_DIGITS-wide hex value on a load strobe and drives NUM_DIGITS active-low 7-segment fields.
- Adds three modes: global enable/blank, leading-zero blanking, and per-digit blink from a free-running divider.
- Sits between datapath registers and the HEX pins; successor to the single-digit combinational decoder.

Parameters:
NUM_DIGITS, 4, number of hex digits/displays driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (≥2); 0.5 s at 50 MHz
CNT_W, 25, blink counter width; must satisfy 2^CNT_W ≥ BLINK_DIV

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  capture value on this edge
value  input  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 least significant
enable  input  1  0 blanks all digits
lzb  input  1  leading-zero blanking enable
blink_mask  input  NUM_DIGITS  bit i=1: digit i blinks
segs  output  7*NUM_DIGITS  digit i segments at segs[7i+6:7i], bit order a..g = 0..6, active-low
blink_phase  output  1  0 = on half-period, 1 = off half-period

Behaviour:
- One clock; reset is synchronous and active-high, named reset; clock named clock.
- Reset (takes priority over everything, including load): value_q=0, blink counter=0, blink_phase=0, segs=all 1s (all digits dark).
- value_q: loaded from value on an edge with load=1; held otherwise. Back-to-back loads each capture the current value.
- segs is a register computed from value_q, enable, lzb, blink_mask and blink_phase as they stand before the edge.
- Latency: load at edge k → value_q updated at k → segs shows new digits after edge k+1. enable/lzb/blink_mask/blink_phase changes also reach segs one edge later.
- Decode, active-low, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blank digit = 1111111.
- Blank priority per digit (any true → blank):
  - enable=0
  - lzb=1 and digit is a leading zero: digit i≥1 is zero and every digit above i is zero. Digit 0 is never blanked by lzb, so value 0 shows a single "0".
  - blink_mask[i]=1 and blink_phase=1.
- Blink divider:
  - Counter increments every cycle, independent of load/enable.
  - When counter == BLINK_DIV-1: counter wraps to 0 and blink_phase toggles on the same edge.
  - Full period = 2*BLINK_DIV cycles.
- Reset mid-blink restarts the counter at 0, phase 0. Reset with load=1 discards the load.
- NUM_DIGITS=1: lzb has no effect.
- Pure registers, no combinational path from inputs to segs.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, BLINK_DIV=4.

1. Reset → segs=0x0FFFFFFF (all 28 bits 1), blink_phase=0. Hold load=1, value=16'h1234 during reset → value_q stays 0. Deassert reset, enable=1, lzb=0, load=0 → segs shows 0000.
2. Exhaustive decode: load value=16'hFEDC, then 16'hBA98, 16'h7654, 16'h3210, enable=1. Two edges after each load → each field matches the decode list, e.g. segs[6:0]=1000000 for digit 0 of 3210.
3. Leading zeros: lzb=1.
   - load 16'h00A0 → digits 3,2 = 1111111; digit 1 = 0001000; digit 0 = 1000000.
   - load 16'h0000 → only digit 0 lit, showing 1000000.
   - load 16'h0F00 → digit 3 blank; digits 1,0 show 0.
4. Blink: value=16'h8888, blink_mask=4'b0101, lzb=0.
   - blink_phase toggles every 4 cycles.
   - During phase 1, digits 0 and 2 are 1111111 while digits 1 and 3 stay 0000000; this appears one edge after the toggle.
   - Pulse load mid-period → counter period unchanged.
5. enable=0 with load of 16'h1234 → segs all 1s. Raise enable → 1234 decoded one edge later, with no reload needed.
6. Reset asserted mid-blink (counter=2, phase=1) → next edge: phase=0, segs all 1s. Next toggle occurs exactly 4 cycles after reset deasserts.
